prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Sequences one config-cell program run: fetches opcodes from the instruction RAM
//  via a 1-cycle-latency read port and streams them to the config cells over a
//  valid/ready handshake. Controlled by start/abort from the host controller.
//  Replaces free-running fetch with bounded, flow-controlled, restartable runs.
// PARAMETERS
//  BLOCK_BITS  3   address bits per symmetric axis; BC=(BLOCK_BITS+1)*2
//  ADDR_BITS   6   cell address bits
//  MODE_BITS   2   mode field bits
//  TOC_WIDTH   4   type-of-code field bits
//  PC_BITS     12  program counter width is PC_BITS+1
//  FIFO_DEPTH  4   output buffer entries (>=2, power of 2)
//  CW = TOC_WIDTH+2*(BC+ADDR_BITS+MODE_BITS)+1 (opcode width, 37 at defaults)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          async reset, active-low
//  start      in   1          run request, sampled only in IDLE
//  abort      in   1          cancel run, priority over start
//  base_addr  in   PC_BITS+1  first opcode address, latched on accepted start
//  prog_len   in   PC_BITS+1  opcodes to fetch, latched on accepted start
//  mem_en     out  1          RAM read strobe
//  mem_addr   out  PC_BITS+1  RAM read address
//  mem_data   in   CW         RAM data, valid the cycle after mem_en
//  code_out   out  CW         opcode to config cells
//  code_valid out  1          code_out valid
//  code_ready in   1          config cells accept
//  busy       out  1          high in any state except IDLE
//  done       out  1          1-cycle pulse on normal completion
//  err        out  1          sticky address-wrap flag, cleared on accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; FIFO empty; in-flight cleared.
//  States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 & abort=0 latches base/len, clears err, goes RUN; prog_len=0 goes DONE.
//  RUN: mem_en=1 when occupancy+in-flight < FIFO_DEPTH; mem_addr=fetch ptr, ptr+1
//   per strobe. Stop fetching after prog_len strobes or end marker, then DRAIN.
//  End marker: mem_data == 0 terminates; marker not written to FIFO; data from reads
//   issued after the marker's read is discarded.
//  Latency: start at edge E0 -> mem_en during E0..E1 -> write at E2 -> code_valid
//   from E2. With code_ready=1, one opcode per cycle, no bubbles.
//  Handshake: transfer on code_valid&code_ready; code_out stable while valid&!ready;
//   code_valid never drops without a transfer, except on abort.
//  DRAIN: waits for in-flight=0 & FIFO empty -> DONE; done=1 one cycle -> IDLE.
//  Pointer wrap: ptr wraps mod 2**(PC_BITS+1); wrap sets err=1, run continues.
//  abort (non-IDLE): next edge FIFO flushed, code_valid=0, busy=0, IDLE, no done;
//   pending read data dropped. abort in IDLE ignored.
//  start while busy: ignored. Simultaneous start+abort in IDLE: start ignored.
//  Async reset mid-run: immediate return to reset state; pending RAM data ignored.
// CONFIGURATION
//  PROG_SEQ_LOOP_EN defined: adds input loop_cnt[7:0], latched on start; program
//   runs loop_cnt+1 passes. After a pass's last fetch, ptr reloads base_addr next cycle
//   with no bubble. End marker ends the current pass only.
//  PROG_SEQ_LOOP_EN undefined: no loop_cnt port; single pass only.
// TESTING
//  base=0x010,len=4,ready=1 -> mem[0x10..0x13] on code_out cycles E2..E5; done at E6.
//  len=8, ready=0 five cycles mid-run -> code_out held; mem_en=0 when FIFO full;
//   all 8 opcodes delivered in order, none lost or duplicated.
//  len=8, mem[base+2]=0 -> exactly 2 opcodes issued, then done; marker never output.
//  abort 3 cycles into len=16 run -> next cycle busy=0, code_valid=0, no done;
//   following start base=0,len=2 delivers 2 opcodes correctly.
//  len=0 -> done one cycle after start, code_valid stays 0; base=0x1FFF,len=2
//   -> mem_addr 0x1FFF then 0x0000, err=1 until next start.
//  PROG_SEQ_LOOP_EN: loop_cnt=2, len=3 -> 9 opcodes (pattern x3), single done.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches one program of opcodes from instruction RAM and streams them
// over valid/ready. Define PROG_SEQ_LOOP_EN to add loop_cnt (repeat the program loop_cnt+1 times).
module prog_sequencer #(
    parameter int BLOCK_BITS = 3,
    parameter int ADDR_BITS  = 6,
    parameter int MODE_BITS  = 2,
    parameter int TOC_WIDTH  = 4,
    parameter int PC_BITS    = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int BC = (BLOCK_BITS + 1) * 2,
    localparam int CW = TOC_WIDTH + 2 * (BC + ADDR_BITS + MODE_BITS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_BITS:0] base_addr,
    input  logic [PC_BITS:0] prog_len,
`ifdef PROG_SEQ_LOOP_EN
    input  logic [7:0]       loop_cnt,
`endif
    output logic             mem_en,
    output logic [PC_BITS:0] mem_addr,
    input  logic [CW-1:0]    mem_data,
    output logic [CW-1:0]    code_out,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int PW    = PC_BITS + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    base_reg;
    logic [PW-1:0]    len_reg;
    logic [PW-1:0]    rem_reg;
    logic             rd_pending_reg;
    logic             rd_last_reg;
    logic             err_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
`ifdef PROG_SEQ_LOOP_EN
    logic [7:0]       pass_left_reg;
`endif

    logic             flush;
    logic             fetch_room;
    logic             marker_hit;
    logic             rd_write;
    logic             fifo_wr;
    logic             pop;
    logic             last_fetch;
    logic             more_passes;
    logic             drain_done;
    logic [CNT_W:0]   occ;
    logic [CW-1:0]    fifo_q [FIFO_DEPTH];

    assign flush = abort && (state_reg != S_IDLE);

    // Reads already in flight reserve a slot so the FIFO can never overflow.
    assign occ        = {1'b0, count_reg} + {{CNT_W{1'b0}}, rd_pending_reg};
    assign fetch_room = occ < (CNT_W + 1)'(FIFO_DEPTH);

    // A zero word ends the pass, unless it belongs to the final read of a pass
    // that has already been closed off by the length count.
    assign marker_hit = rd_pending_reg && (mem_data == '0) && (state_reg == S_RUN) && !rd_last_reg;

    assign mem_en     = (state_reg == S_RUN) && fetch_room && !marker_hit && !abort;
    assign mem_addr   = ptr_reg;
    assign last_fetch = mem_en && (rem_reg == PW'(1));

    assign rd_write   = rd_pending_reg && (mem_data != '0);
    assign fifo_wr    = rd_write && !flush;
    assign code_valid = (count_reg != '0);
    assign pop        = code_valid && code_ready;
    assign code_out   = code_valid ? fifo_q[rd_ptr_reg] : '0;

    assign drain_done = !rd_pending_reg &&
                        ((count_reg == '0) || ((count_reg == CNT_W'(1)) && pop));

`ifdef PROG_SEQ_LOOP_EN
    assign more_passes = (pass_left_reg != 8'd0);
`else
    assign more_passes = 1'b0;
`endif

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);
    assign err  = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [CW-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_reg <= '0;
                end else if (fifo_wr && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= mem_data;
                end
            end
            assign fifo_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            ptr_reg        <= '0;
            base_reg       <= '0;
            len_reg        <= '0;
            rem_reg        <= '0;
            rd_pending_reg <= 1'b0;
            rd_last_reg    <= 1'b0;
            err_reg        <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
`ifdef PROG_SEQ_LOOP_EN
            pass_left_reg  <= 8'd0;
`endif
        end else if (flush) begin
            // Abort: drop buffered and in-flight data, no done pulse.
            state_reg      <= S_IDLE;
            rd_pending_reg <= 1'b0;
            rd_last_reg    <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            rd_pending_reg <= mem_en;
            rd_last_reg    <= last_fetch;
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(fifo_wr) - CNT_W'(pop);

            if (mem_en) begin
                ptr_reg <= ptr_reg + PW'(1);
                rem_reg <= rem_reg - PW'(1);
                if (ptr_reg == '1) begin
                    err_reg <= 1'b1;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    if (start && !abort) begin
                        base_reg  <= base_addr;
                        len_reg   <= prog_len;
                        ptr_reg   <= base_addr;
                        rem_reg   <= prog_len;
                        err_reg   <= 1'b0;
`ifdef PROG_SEQ_LOOP_EN
                        pass_left_reg <= loop_cnt;
`endif
                        state_reg <= (prog_len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_fetch || marker_hit) begin
                        if (more_passes) begin
                            // Next pass starts fetching on the very next cycle.
                            ptr_reg <= base_reg;
                            rem_reg <= len_reg;
`ifdef PROG_SEQ_LOOP_EN
                            pass_left_reg <= pass_left_reg - 8'd1;
`endif
                        end else begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: expected opcodes are queued from the bench RAM
// image when a run is launched and compared as each handshake completes.
module tb_prog_sequencer;

    localparam int PW = 13;
    localparam int CW = 37;
    localparam int RAM_WORDS = 1 << PW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] base_addr = '0;
    logic [PW-1:0] prog_len = '0;
    logic [7:0]    loop_cnt = 8'd0;
    logic          mem_en;
    logic [PW-1:0] mem_addr;
    logic [CW-1:0] mem_data = '0;
    logic [CW-1:0] code_out;
    logic          code_valid;
    logic          code_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          err;

    logic [CW-1:0] ram [RAM_WORDS];
    logic [CW-1:0] exp_q [$];
    logic [CW-1:0] mon_exp;
    int            n_vec = 0;
    int            n_err = 0;
    int            done_cnt = 0;
    int            xfer_cnt = 0;
    int            d0;
    int            x0;

    always #5 clk = ~clk;

    prog_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .prog_len   (prog_len),
`ifdef PROG_SEQ_LOOP_EN
        .loop_cnt   (loop_cnt),
`endif
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Instruction RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en) mem_data <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (done) done_cnt <= done_cnt + 1;
            if (code_valid && !code_ready && exp_q.size() > 0)
                check("hold", 64'(code_out), 64'(exp_q[0]));
            if (code_valid && code_ready) begin
                xfer_cnt <= xfer_cnt + 1;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    $display("xfer: code_out=%h expected=%h", code_out, mon_exp);
                    check("code_out", 64'(code_out), 64'(mon_exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int base, input int len, input int passes);
        logic [CW-1:0] w;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < len; i++) begin
                w = ram[(base + i) % RAM_WORDS];
                if (w == '0) break;
                exp_q.push_back(w);
            end
        end
    endtask

    // Returns just after the edge (E0) that accepts the start.
    task automatic launch(input int base, input int len);
        base_addr = PW'(base);
        prog_len  = PW'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check(tag, 64'(seen), 64'd1);
        tick();
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < RAM_WORDS; a++)
            ram[a] = {12'hABC, 12'(a), 13'(a) ^ 13'h1555};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_valid", 64'(code_valid), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_code", 64'(code_out), 64'd0);
        rst = 1'b1;
        tick();

        // Basic run and latency
        push_expected(16, 4, 1);
        d0 = done_cnt;
        launch(16, 4);
        check("t1_mem_en", 64'(mem_en), 64'd1);
        check("t1_addr", 64'(mem_addr), 64'h10);
        tick();
        check("t1_valid_e1", 64'(code_valid), 64'd0);
        tick();
        check("t1_valid_e2", 64'(code_valid), 64'd1);
        repeat (4) tick();
        check("t1_done_e6", 64'(done), 64'd1);
        tick();
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_sb_empty", 64'(exp_q.size()), 64'd0);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Back-pressure fills the FIFO
        push_expected(64, 8, 1);
        d0 = done_cnt;
        launch(64, 8);
        tick();
        tick();
        code_ready = 1'b0;
        repeat (5) tick();
        check("t2_full_no_fetch", 64'(mem_en), 64'd0);
        check("t2_valid_held", 64'(code_valid), 64'd1);
        code_ready = 1'b1;
        wait_done("t2_done");
        check("t2_sb_empty", 64'(exp_q.size()), 64'd0);
        check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

        // End marker
        ram[16'h82] = '0;
        push_expected(16'h80, 8, 1);
        x0 = xfer_cnt;
        launch(16'h80, 8);
        wait_done("t3_done");
        check("t3_xfers", 64'(xfer_cnt - x0), 64'd2);
        check("t3_sb_empty", 64'(exp_q.size()), 64'd0);
        ram[16'h82] = {12'hABC, 12'h082, 13'h082 ^ 13'h1555};

        // Abort mid-run, then a fresh run
        push_expected(16'h100, 16, 1);
        d0 = done_cnt;
        launch(16'h100, 16);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_valid", 64'(code_valid), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        exp_q.delete();
        repeat (3) tick();
        check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        push_expected(0, 2, 1);
        launch(0, 2);
        wait_done("t4_rerun_done");
        check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

        // Zero-length program
        launch(16'h30, 0);
        check("t5_done", 64'(done), 64'd1);
        check("t5_valid", 64'(code_valid), 64'd0);
        tick();
        check("t5_busy", 64'(busy), 64'd0);

        // Address wrap
        push_expected(13'h1FFF, 2, 1);
        launch(13'h1FFF, 2);
        check("t6_addr0", 64'(mem_addr), 64'h1FFF);
        tick();
        check("t6_addr1", 64'(mem_addr), 64'h0000);
        check("t6_mem_en1", 64'(mem_en), 64'd1);
        wait_done("t6_done");
        check("t6_err", 64'(err), 64'd1);
        check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

        // Abort alone and start+abort in IDLE are ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t7_abort_idle", 64'(busy), 64'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t7_start_abort", 64'(busy), 64'd0);
        check("t7_err_kept", 64'(err), 64'd1);
        push_expected(16'h20, 1, 1);
        launch(16'h20, 1);
        check("t7_err_clr", 64'(err), 64'd0);
        wait_done("t7_done");
        check("t7_sb_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a run
        push_expected(16'h300, 16, 1);
        launch(16'h300, 16);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("t8_busy", 64'(busy), 64'd0);
        check("t8_valid", 64'(code_valid), 64'd0);
        check("t8_mem_en", 64'(mem_en), 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();
        push_expected(16'h40, 3, 1);
        launch(16'h40, 3);
        wait_done("t8_rerun_done");
        check("t8_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef PROG_SEQ_LOOP_EN
        // Three passes over a three-opcode program
        loop_cnt = 8'd2;
        push_expected(16'h200, 3, 3);
        d0 = done_cnt;
        x0 = xfer_cnt;
        launch(16'h200, 3);
        wait_done("t9_done");
        repeat (2) tick();
        check("t9_xfers", 64'(xfer_cnt - x0), 64'd9);
        check("t9_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t9_sb_empty", 64'(exp_q.size()), 64'd0);
        loop_cnt = 8'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
